// File: rtl/slice_chk_pkg.sv
// slice_chk_pkg: shared types and constants for the slice stimulus checker.
//   state_t   - checker FSM state encoding
//   LFSR_POLY - Galois LFSR feedback polynomial (shift-right form)
//   SLICE_W   - bit width of one compared slice
//   lfsr_next - one step of the pattern generator
//   bit_rev32 - 32-bit bit reversal used to derive the B pattern
package slice_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam int          SLICE_W   = 4;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  function automatic logic [31:0] bit_rev32(input logic [31:0] s);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = s[31-i];
    return r;
  endfunction

endpackage

// File: rtl/slice_stim_checker_if.sv
// slice_stim_checker_if: bus between the checker and the slice netlist.
//   a_o  - stimulus for the netlist A bus
//   b_o  - stimulus for the netlist B bus (netlist side is inout)
//   b_oe - B-bus drive enable
//   c_i  - netlist C-bus response
// master = checker side, slave = netlist side.
interface slice_stim_checker_if #(
  parameter int WIDTH = 41
);
  logic [WIDTH-1:0] a_o;
  logic [WIDTH-1:0] b_o;
  logic             b_oe;
  logic [WIDTH-1:0] c_i;

  modport master (output a_o, output b_o, output b_oe, input c_i);
  modport slave  (input a_o, input b_o, input b_oe, output c_i);
endinterface

// File: rtl/slice_golden.sv
// slice_golden: combinational golden model of one 4-bit slice.
//   a, b  - slice inputs (4 bits each)
//   exp_o - expected slice C output
module slice_golden (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] exp_o
);

  assign exp_o[0] = ~a[0];
  assign exp_o[1] = ~b[0];
  assign exp_o[2] = ~b[1];
  assign exp_o[3] = ~((a[1] | a[2]) & (b[1] | b[2]) & (a[3] | b[3]));

endmodule

// File: rtl/slice_stim_checker.sv
// slice_stim_checker: drives LFSR-generated A/B patterns onto a slice
// netlist, waits SETTLE cycles, then compares C against the golden model
// over all complete 4-bit slices and records the error statistics.
//   clk, rst        - clock, async active-high reset
//   start           - run request (IDLE only)
//   num_patterns    - patterns per run, sampled with start
//   seed            - LFSR seed, sampled with start (0 is treated as 1)
//   bus             - netlist A/B/C bus (master side)
//   busy, done      - run in progress / one-cycle end-of-run pulse
//   pass            - last run had no mismatches
//   err_cnt         - mismatching patterns in current/last run
//   first_fail_idx  - index of first mismatch, 0xFFFF if none
//   first_fail_c    - C captured at first mismatch, 0 if none
//
// state    | meaning
// ---------+---------------------------------------------------
// ST_IDLE  | waiting for start
// ST_DRIVE | pattern driven, settle down-counter running
// ST_CHECK | pattern still driven, C compared against golden
// ST_DONE  | one-cycle done pulse, result published
module slice_stim_checker
  import slice_chk_pkg::*;
#(
  parameter int WIDTH  = 41,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [15:0]          num_patterns,
  input  logic [31:0]          seed,
  slice_stim_checker_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_cnt,
  output logic [15:0]          first_fail_idx,
  output logic [WIDTH-1:0]     first_fail_c
);

  localparam int NSLICE  = WIDTH / SLICE_W;
  localparam int CMP_W   = NSLICE * SLICE_W;
  // Only complete slices are compared; leftover top bits are masked off.
  localparam logic [WIDTH-1:0] CMP_MASK = {WIDTH{1'b1}} >> (WIDTH - CMP_W);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t           state;
  logic [31:0]      lfsr;
  logic [15:0]      idx;
  logic [15:0]      num_q;
  logic [3:0]       settle_cnt;
  logic [WIDTH-1:0] a_q, b_q;
  logic             b_oe_q;
  logic [WIDTH-1:0] exp_c;
  logic             mismatch;
  logic [31:0]      seed_eff;
  logic [31:0]      lfsr_nxt;

  function automatic logic [WIDTH-1:0] pat_a(input logic [31:0] s);
    logic [63:0] d;
    d = {s, s};
    return WIDTH'(d);
  endfunction

  function automatic logic [WIDTH-1:0] pat_b(input logic [31:0] s);
    logic [31:0] r;
    logic [63:0] d;
    r = bit_rev32(s);
    d = {r, r};
    return WIDTH'(d);
  endfunction

  for (genvar g = 0; g < NSLICE; g++) begin : g_slice
    slice_golden u_golden (
      .a     (a_q[g*SLICE_W +: SLICE_W]),
      .b     (b_q[g*SLICE_W +: SLICE_W]),
      .exp_o (exp_c[g*SLICE_W +: SLICE_W])
    );
  end

  if (WIDTH > CMP_W) begin : g_tail
    assign exp_c[WIDTH-1:CMP_W] = '0;
  end

  assign mismatch = |((bus.c_i ^ exp_c) & CMP_MASK);
  assign seed_eff = (seed == 32'h0) ? 32'h1 : seed;
  assign lfsr_nxt = lfsr_next(lfsr);

  assign bus.a_o  = a_q;
  assign bus.b_o  = b_q;
  assign bus.b_oe = b_oe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      lfsr           <= 32'h1;
      idx            <= '0;
      num_q          <= '0;
      settle_cnt     <= '0;
      a_q            <= '0;
      b_q            <= '0;
      b_oe_q         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      first_fail_idx <= 16'hFFFF;
      first_fail_c   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            num_q          <= num_patterns;
            idx            <= '0;
            err_cnt        <= '0;
            first_fail_idx <= 16'hFFFF;
            first_fail_c   <= '0;
            if (num_patterns == 16'h0) begin
              state <= ST_DONE;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              pass       <= 1'b0;
              lfsr       <= seed_eff;
              a_q        <= pat_a(seed_eff);
              b_q        <= pat_b(seed_eff);
              b_oe_q     <= 1'b1;
              busy       <= 1'b1;
              settle_cnt <= SETTLE_LOAD;
              state      <= ST_DRIVE;
            end
          end
        end
        ST_DRIVE: begin
          if (settle_cnt == 4'h0) state <= ST_CHECK;
          else settle_cnt <= settle_cnt - 4'h1;
        end
        ST_CHECK: begin
          if (mismatch) begin
            err_cnt <= err_cnt + 16'h1;
            if (err_cnt == 16'h0) begin
              first_fail_idx <= idx;
              first_fail_c   <= bus.c_i;
            end
          end
          lfsr <= lfsr_nxt;
          if (idx == num_q - 16'h1) begin
            state  <= ST_DONE;
            done   <= 1'b1;
            busy   <= 1'b0;
            b_oe_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            // err_cnt is still updating this edge, so fold in this pattern.
            pass   <= (err_cnt == 16'h0) && !mismatch;
          end else begin
            idx        <= idx + 16'h1;
            a_q        <= pat_a(lfsr_nxt);
            b_q        <= pat_b(lfsr_nxt);
            settle_cnt <= SETTLE_LOAD;
            state      <= ST_DRIVE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slice_stim_checker.sv
module tb_slice_stim_checker;

  localparam int W  = 41;
  localparam int S  = 2;
  localparam int NS = W / 4;
  localparam logic [W-1:0] CMASK = W'((64'h1 << (4*NS)) - 64'h1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   num_patterns;
  logic [31:0]   seed;
  logic          busy, done, pass;
  logic [15:0]   err_cnt, first_fail_idx;
  logic [W-1:0]  first_fail_c;

  slice_stim_checker_if #(.WIDTH(W)) bus ();

  slice_stim_checker #(.WIDTH(W), .SETTLE(S)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_patterns   (num_patterns),
    .seed           (seed),
    .bus            (bus),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_cnt        (err_cnt),
    .first_fail_idx (first_fail_idx),
    .first_fail_c   (first_fail_c)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic lsb;
    lsb = s[0];
    s = s >> 1;
    if (lsb) s = s ^ 32'h8020_0003;
    return s;
  endfunction

  function automatic logic [W-1:0] ref_a(input logic [31:0] s);
    logic [63:0] d;
    d = {s, s};
    return d[W-1:0];
  endfunction

  function automatic logic [W-1:0] ref_b(input logic [31:0] s);
    logic [31:0] r;
    logic [63:0] d;
    for (int i = 0; i < 32; i++) r[i] = s[31-i];
    d = {r, r};
    return d[W-1:0];
  endfunction

  function automatic logic [W-1:0] ref_exp(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] e;
    e = '0;
    for (int k = 0; k < NS; k++) begin
      int q;
      q = 4*k;
      e[q]   = ~a[q];
      e[q+1] = ~b[q];
      e[q+2] = ~b[q+1];
      e[q+3] = ~((a[q+1] | a[q+2]) & (b[q+1] | b[q+2]) & (a[q+3] | b[q+3]));
    end
    return e;
  endfunction

  // Netlist model: golden slices, optional C[0]=A[0] fault, noise on the
  // uncompared top bit so masking is exercised.
  function automatic logic [W-1:0] netlist(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic flt);
    logic [W-1:0] c;
    c = ref_exp(a, b);
    if (flt) c[0] = a[0];
    c[W-1] = a[W-1] ^ b[W-1] ^ 1'b1;
    return c;
  endfunction

  logic         fault_mode;
  logic [W-1:0] corrupt_cur;

  always_comb bus.c_i = netlist(bus.a_o, bus.b_o, fault_mode) ^ corrupt_cur;

  logic [W-1:0] pa [16];
  logic [W-1:0] pb [16];
  logic [W-1:0] corr [16];

  // Caller must be in an IDLE cycle, shortly after a rising edge.
  task automatic run(input logic [31:0] sd, input int n, input logic flt,
                     input bit rnd_corr, input bit hold, input string name);
    logic [31:0]  s;
    int           e_err, e_fi, total, idx;
    logic [W-1:0] e_fc, c;
    bit           done_seen;

    s = (sd == 32'h0) ? 32'h1 : sd;
    e_err = 0; e_fi = 16'hFFFF; e_fc = '0;
    for (int i = 0; i < n; i++) begin
      pa[i] = ref_a(s);
      pb[i] = ref_b(s);
      corr[i] = '0;
      if (rnd_corr) begin
        case ($urandom_range(0, 2))
          1: corr[i][$urandom_range(0, 4*NS-1)] = 1'b1;
          2: corr[i][W-1] = 1'b1;
          default: ;
        endcase
      end
      c = netlist(pa[i], pb[i], flt) ^ corr[i];
      if (((c ^ ref_exp(pa[i], pb[i])) & CMASK) != '0) begin
        if (e_err == 0) begin e_fi = i; e_fc = c; end
        e_err++;
      end
      s = ref_step(s);
    end
    total = n * (S + 1);

    fault_mode   = flt;
    corrupt_cur  = '0;
    num_patterns = 16'(n);
    seed         = sd;
    start        = 1'b1;
    done_seen    = 1'b0;
    @(posedge clk);
    for (int cyc = 1; cyc <= total + 6 && !done_seen; cyc++) begin
      if (cyc > 1) @(posedge clk);
      #1;
      if (!hold) start = 1'b0;
      idx = (cyc - 1) / (S + 1);
      if (cyc <= total) begin
        corrupt_cur = corr[idx];
        check({name, " busy"}, busy, 1);
        check({name, " b_oe"}, bus.b_oe, 1);
        check({name, " a_o"},  bus.a_o, pa[idx]);
        check({name, " b_o"},  bus.b_o, pb[idx]);
      end else begin
        corrupt_cur = '0;
      end
      check({name, " done"}, done, cyc == total + 1);
      if (done) begin
        done_seen = 1'b1;
        start = 1'b0;
        check({name, " done_cycle"}, cyc, total + 1);
        check({name, " pass"}, pass, e_err == 0);
        check({name, " err_cnt"}, err_cnt, e_err);
        check({name, " first_fail_idx"}, first_fail_idx, e_fi);
        check({name, " first_fail_c"}, first_fail_c, e_fc);
        check({name, " busy_at_done"}, busy, 0);
        check({name, " b_oe_at_done"}, bus.b_oe, 0);
        check({name, " ab_at_done"}, {bus.a_o, bus.b_o} == '0, 1);
      end
    end
    if (!done_seen) begin
      check({name, " timeout"}, 0, 1);
      start = 1'b0;
    end
    // Two idle cycles: single done pulse, no relaunch, result held.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check({name, " post_done"}, done, 0);
      check({name, " post_busy"}, busy, 0);
      check({name, " post_pass"}, pass, e_err == 0);
    end
  endtask

  task automatic check_reset_vals(input string name);
    check({name, " a_o"}, bus.a_o, 0);
    check({name, " b_o"}, bus.b_o, 0);
    check({name, " b_oe"}, bus.b_oe, 0);
    check({name, " busy"}, busy, 0);
    check({name, " done"}, done, 0);
    check({name, " pass"}, pass, 0);
    check({name, " err_cnt"}, err_cnt, 0);
    check({name, " first_fail_idx"}, first_fail_idx, 16'hFFFF);
    check({name, " first_fail_c"}, first_fail_c, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_patterns = '0; seed = '0;
    fault_mode = 1'b0; corrupt_cur = '0;
    #1;
    check_reset_vals("reset");
    #11 rst = 1'b0;
    @(posedge clk); #1;

    run(32'h1, 4, 1'b0, 1'b0, 1'b0, "golden");
    run(32'h1, 5, 1'b1, 1'b0, 1'b0, "fault_c0");
    run(32'h1, 0, 1'b0, 1'b0, 1'b0, "num0");
    run(32'h0, 4, 1'b0, 1'b0, 1'b0, "seed0");
    for (int t = 0; t < 6; t++)
      run($urandom, $urandom_range(1, 12), 1'($urandom_range(0, 1)), 1'b1, 1'b0, "random");
    run($urandom, 3, 1'b0, 1'b1, 1'b1, "hold_start");

    // Mid-run reset: abort in cycle 5 of a 10-pattern run.
    num_patterns = 16'd10; seed = $urandom; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_vals("midrun_rst");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("midrun_rst no_done", done, 0);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check_reset_vals("after_rst");
    run(32'h1, 4, 1'b0, 1'b0, 1'b0, "rst_restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 want=0");
    $fatal(1, "timeout");
  end

endmodule
